// File: rtl/sump_pkg.sv
// Shared SUMP command definitions: opcodes, command-length rule and the
// serializer FSM state encoding.
package sump_pkg;

    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_ARM   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_XON   = 8'h11;
    localparam logic [7:0] OP_XOFF  = 8'h13;
    localparam logic [7:0] OP_FLAGS = 8'h82;

    localparam int LONG_CMD_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_PAUSE = 3'd4
    } tx_state_e;

    // Index of the final byte: long commands carry four operand bytes after the opcode.
    function automatic logic [2:0] last_byte_idx(input logic [7:0] op);
        logic [2:0] idx;
        if (op[LONG_CMD_BIT]) begin
            idx = 3'd4;
        end else begin
            idx = 3'd0;
        end
        return idx;
    endfunction

    function automatic logic [7:0] cmd_byte(input logic [7:0]  op,
                                            input logic [31:0] data,
                                            input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = op;
            3'd1:    b = data[7:0];
            3'd2:    b = data[15:8];
            3'd3:    b = data[23:16];
            3'd4:    b = data[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sump_cmd_tx_if.sv
// Command handshake between a host-side producer and the SUMP command serializer.
interface sump_cmd_tx_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [31:0] cmd_data;

    modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: runs 0..DIVISOR-1 and flags the last clock of each bit.
module uart_bit_timer #(
    parameter int DIVISOR = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: held at zero while cleared, otherwise wraps at the bit boundary.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !clr && (cnt_q == LAST);

endmodule

// File: rtl/sump_cmd_tx.sv
// SUMP host command serializer: one {opcode, operand} per handshake out as
// 8N1 UART frames (1 byte for short opcodes, 5 for long ones).
module sump_cmd_tx
    import sump_pkg::*;
#(
    parameter int FREQ    = 100000000,
    parameter int RATE    = 115200,
    parameter int DIVISOR = FREQ / RATE
) (
    input  logic                clock,
    input  logic                reset,
    sump_cmd_tx_if.slave        cmd,
    input  logic                hold,
    output logic                tx,
    output logic                busy,
    output logic                done
);

    generate
        if (DIVISOR < 2) begin : g_bad_divisor
            $error("sump_cmd_tx: DIVISOR must be at least 2");
        end
    endgenerate

    tx_state_e   state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  byte_idx_q, byte_idx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;

    logic        accept_s;
    logic        bit_tick_s;
    logic        timer_clr_s;
    logic        last_byte_s;

    assign accept_s    = cmd.cmd_valid && (state_q == ST_IDLE);
    // The timer idles at zero outside frames so each frame starts on a full bit.
    assign timer_clr_s = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
    assign last_byte_s = (byte_idx_q == last_byte_idx(op_q));

    uart_bit_timer #(.DIVISOR(DIVISOR)) u_bit_timer (
        .clock (clock),
        .reset (reset),
        .clr   (timer_clr_s),
        .tick  (bit_tick_s)
    );

    // Next-state, byte sequencing and serial-line value.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        byte_idx_d = byte_idx_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                byte_idx_d = 3'd0;
                bit_cnt_d  = 3'd0;
                if (accept_s) begin
                    op_d    = cmd.cmd_op;
                    data_d  = cmd.cmd_data;
                    shift_d = cmd.cmd_op;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    bit_cnt_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick_s) begin
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        state_d   = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_tick_s) begin
                    if (last_byte_s) begin
                        byte_idx_d = 3'd0;
                        done_d     = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // hold is only honoured here, between bytes.
                        byte_idx_d = byte_idx_q + 3'd1;
                        shift_d    = cmd_byte(op_q, data_q, byte_idx_q + 3'd1);
                        if (hold) begin
                            state_d = ST_PAUSE;
                        end else begin
                            state_d = ST_START;
                        end
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_PAUSE: begin
                if (hold) begin
                    state_d = ST_PAUSE;
                end else begin
                    state_d = ST_START;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // State, command latch and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 8'h00;
            data_q     <= 32'h0000_0000;
            byte_idx_q <= 3'd0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            data_q     <= data_d;
            byte_idx_q <= byte_idx_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign busy          = (state_q != ST_IDLE);
    assign tx            = tx_q;
    assign done          = done_q;

endmodule
